// File: rtl/cc_pkg.sv
// Shared cache-controller definitions: bus widths and the R-channel serializer state type.
package cc_pkg;

    localparam int unsigned CC_DATA_WIDTH   = 64;
    localparam int unsigned CC_LINE_WIDTH   = 512;
    localparam int unsigned CC_BEATS        = CC_LINE_WIDTH / CC_DATA_WIDTH;
    localparam int unsigned CC_OFFSET_WIDTH = 6;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } cc_ser_state_t;

endpackage

// File: rtl/cc_rdata_serializer.sv
// Streams a completed cache line from the response FIFO as one 8-beat R burst,
// critical word first with wrap-around; back-to-back lines need no idle cycle.
module cc_rdata_serializer
    import cc_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = CC_DATA_WIDTH,
    parameter int unsigned LINE_WIDTH = CC_LINE_WIDTH
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       fifo_empty_i,
    input  logic [LINE_WIDTH-1:0]      fifo_line_i,
    input  logic [CC_OFFSET_WIDTH-1:0] fifo_offset_i,
    output logic                       fifo_rden_o,
    output logic [DATA_WIDTH-1:0]      inct_rdata_o,
    output logic [1:0]                 inct_rresp_o,
    output logic                       inct_rlast_o,
    output logic                       inct_rvalid_o,
    input  logic                       inct_rready_i
);

    localparam int unsigned BEATS   = LINE_WIDTH / DATA_WIDTH;
    localparam int unsigned IDX_W   = $clog2(BEATS);
    localparam int unsigned BYTE_SH = $clog2(DATA_WIDTH / 8);
    localparam logic [IDX_W-1:0] LAST_BEAT = IDX_W'(BEATS - 1);

    cc_ser_state_t                   state_q, state_d;
    logic [BEATS-1:0][DATA_WIDTH-1:0] line_q;
    logic [IDX_W-1:0]                word_idx_q;
    logic [IDX_W-1:0]                beat_cnt_q;
    logic                            handshake;
    logic                            pop;
    logic [IDX_W-1:0]                start_word;
    logic                            unused_offset_lsbs;

    // Byte-within-word bits of the request offset do not affect beat order.
    assign start_word         = fifo_offset_i[BYTE_SH +: IDX_W];
    assign unused_offset_lsbs = ^fifo_offset_i[BYTE_SH-1:0];

    assign handshake = (state_q == SEND) && inct_rready_i;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and pop strobe; a new line is only taken between bursts.
    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty_i) begin
                    pop     = 1'b1;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (handshake && (beat_cnt_q == LAST_BEAT)) begin
                    if (!fifo_empty_i) begin
                        pop = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        if (!rst_n) begin
            pop = 1'b0;
        end
    end

    // Line buffer, wrapping word pointer and beat counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            line_q     <= '0;
            word_idx_q <= '0;
            beat_cnt_q <= '0;
        end else if (pop) begin
            line_q     <= fifo_line_i;
            word_idx_q <= start_word;
            beat_cnt_q <= '0;
        end else if (handshake) begin
            word_idx_q <= word_idx_q + IDX_W'(1);
            beat_cnt_q <= beat_cnt_q + IDX_W'(1);
        end
    end

    assign fifo_rden_o   = pop;
    assign inct_rvalid_o = (state_q == SEND);
    assign inct_rdata_o  = line_q[word_idx_q];
    assign inct_rlast_o  = (state_q == SEND) && (beat_cnt_q == LAST_BEAT);
    assign inct_rresp_o  = 2'b00;

endmodule

// File: tb/tb_cc_rdata_serializer.sv
// Self-checking bench: directed offset table, back-to-back, reset and empty cases,
// then random traffic against a queue-based model of the expected beat stream.
module tb_cc_rdata_serializer;

    localparam int unsigned DW = 64;
    localparam int unsigned LW = 512;
    localparam int unsigned NB = LW / DW;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          fifo_empty_i;
    logic [LW-1:0] fifo_line_i;
    logic [5:0]    fifo_offset_i;
    logic          fifo_rden_o;
    logic [DW-1:0] inct_rdata_o;
    logic [1:0]    inct_rresp_o;
    logic          inct_rlast_o;
    logic          inct_rvalid_o;
    logic          inct_rready_i;

    cc_rdata_serializer #(.DATA_WIDTH(DW), .LINE_WIDTH(LW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .fifo_empty_i (fifo_empty_i),
        .fifo_line_i  (fifo_line_i),
        .fifo_offset_i(fifo_offset_i),
        .fifo_rden_o  (fifo_rden_o),
        .inct_rdata_o (inct_rdata_o),
        .inct_rresp_o (inct_rresp_o),
        .inct_rlast_o (inct_rlast_o),
        .inct_rvalid_o(inct_rvalid_o),
        .inct_rready_i(inct_rready_i)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [LW-1:0] line;
        logic [5:0]    off;
    } line_t;

    typedef struct {
        logic [DW-1:0] data;
        logic          last;
    } beat_t;

    typedef struct {
        logic [5:0] off;
        int         first_word;
        int         last_word;
    } vec_t;

    line_t fifo_q[$];
    beat_t exp_q[$];
    vec_t  vecs[6];

    int n_tests = 0;
    int n_fail  = 0;

    // Observations gathered by run_cycle for the directed checks.
    int obs_first, obs_last, obs_beats, obs_pops, obs_valid_cycles;
    int obs_first_valid, obs_last_valid, cyc;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_tests++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, expv, $time);
        end
    endtask

    function automatic logic [LW-1:0] make_line(input int id);
        logic [LW-1:0] l;
        for (int w = 0; w < NB; w++) l[w*DW +: DW] = {32'(id), 24'h5A5A5A, 8'(w)};
        return l;
    endfunction

    function automatic logic [LW-1:0] rand_line();
        logic [LW-1:0] l;
        for (int w = 0; w < NB; w++) l[w*DW +: DW] = {$urandom, $urandom};
        return l;
    endfunction

    task automatic push_line(input logic [LW-1:0] l, input logic [5:0] off);
        line_t e;
        e.line = l;
        e.off  = off;
        fifo_q.push_back(e);
    endtask

    // Popping a line schedules its 8 beats starting at the requested word.
    task automatic model_pop();
        line_t e;
        beat_t b;
        int    start;
        e     = fifo_q.pop_front();
        start = int'(e.off) / 8;
        for (int k = 0; k < NB; k++) begin
            b.data = e.line[((start + k) % NB)*DW +: DW];
            b.last = (k == NB - 1);
            exp_q.push_back(b);
        end
    endtask

    task automatic run_cycle(input logic rr);
        logic exp_valid, exp_hs, exp_rden;
        @(negedge clk);
        inct_rready_i = rr;
        fifo_empty_i  = (fifo_q.size() == 0);
        fifo_line_i   = fifo_empty_i ? '0 : fifo_q[0].line;
        fifo_offset_i = fifo_empty_i ? '0 : fifo_q[0].off;
        #1;
        exp_valid = (exp_q.size() != 0);
        exp_hs    = exp_valid && rr;
        exp_rden  = (fifo_q.size() != 0) &&
                    ((exp_q.size() == 0) || (exp_q.size() == 1 && exp_hs));
        check("rvalid", 64'(inct_rvalid_o), 64'(exp_valid));
        check("rden", 64'(fifo_rden_o), 64'(exp_rden));
        if (exp_valid && inct_rvalid_o) begin
            check("rdata", inct_rdata_o, exp_q[0].data);
            check("rlast", 64'(inct_rlast_o), 64'(exp_q[0].last));
            check("rresp", 64'(inct_rresp_o), 64'd0);
        end
        if (inct_rvalid_o) begin
            obs_valid_cycles++;
            if (obs_first_valid < 0) obs_first_valid = cyc;
            obs_last_valid = cyc;
        end
        if (fifo_rden_o) obs_pops++;
        if (exp_hs && inct_rvalid_o) begin
            obs_beats++;
            if (exp_q.size() == NB) obs_first = int'(inct_rdata_o[7:0]);
            if (inct_rlast_o) obs_last = int'(inct_rdata_o[7:0]);
        end
        cyc++;
        @(posedge clk);
        if (exp_hs) void'(exp_q.pop_front());
        if (exp_rden) model_pop();
    endtask

    task automatic clear_obs();
        obs_first = -1; obs_last = -1; obs_beats = 0; obs_pops = 0;
        obs_valid_cycles = 0; obs_first_valid = -1; obs_last_valid = -1; cyc = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0] = '{6'h00, 0, 7};
        vecs[1] = '{6'h2C, 5, 4};
        vecs[2] = '{6'h3F, 7, 6};
        vecs[3] = '{6'h07, 0, 7};
        vecs[4] = '{6'h08, 1, 0};
        vecs[5] = '{6'h1A, 3, 2};

        rst_n = 1'b0; fifo_empty_i = 1'b1; fifo_line_i = '0;
        fifo_offset_i = '0; inct_rready_i = 1'b0;
        #1;
        check("reset_rvalid", 64'(inct_rvalid_o), 64'd0);
        check("reset_rlast", 64'(inct_rlast_o), 64'd0);
        check("reset_rden", 64'(fifo_rden_o), 64'd0);
        check("reset_rdata", inct_rdata_o, 64'd0);
        check("reset_rresp", 64'(inct_rresp_o), 64'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Single lines at different start words.
        foreach (vecs[i]) begin
            clear_obs();
            push_line(make_line(i + 1), vecs[i].off);
            for (int c = 0; c < 11; c++) run_cycle(1'b1);
            check("vec_first_word", 64'(obs_first), 64'(vecs[i].first_word));
            check("vec_last_word", 64'(obs_last), 64'(vecs[i].last_word));
            check("vec_beats", 64'(obs_beats), 64'(NB));
            check("vec_pops", 64'(obs_pops), 64'd1);
            check("vec_valid_cycles", 64'(obs_valid_cycles), 64'(NB));
        end

        // Empty FIFO: nothing happens.
        clear_obs();
        for (int c = 0; c < 10; c++) run_cycle(1'b1);
        check("empty_pops", 64'(obs_pops), 64'd0);
        check("empty_valid", 64'(obs_valid_cycles), 64'd0);

        // Two queued lines stream as 16 consecutive beats.
        clear_obs();
        push_line(make_line(20), 6'h10);
        push_line(make_line(21), 6'h38);
        for (int c = 0; c < 20; c++) run_cycle(1'b1);
        check("b2b_valid_cycles", 64'(obs_valid_cycles), 64'd16);
        check("b2b_span", 64'(obs_last_valid - obs_first_valid + 1), 64'd16);
        check("b2b_pops", 64'(obs_pops), 64'd2);

        // Line arriving mid-burst must wait for the last handshake.
        push_line(make_line(30), 6'h08);
        for (int c = 0; c < 4; c++) run_cycle(1'b1);
        push_line(make_line(31), 6'h30);
        for (int c = 0; c < 20; c++) run_cycle(1'b1);

        // Reset after three accepted beats, with another line waiting.
        push_line(make_line(40), 6'h20);
        push_line(make_line(41), 6'h1A);
        for (int c = 0; c < 20 && !(exp_q.size() == NB - 3 && fifo_q.size() == 1); c++)
            run_cycle(1'b1);
        check("rst_reached_beat3", 64'(exp_q.size()), 64'(NB - 3));
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst_mid_rvalid", 64'(inct_rvalid_o), 64'd0);
        check("rst_mid_rden", 64'(fifo_rden_o), 64'd0);
        check("rst_mid_rlast", 64'(inct_rlast_o), 64'd0);
        exp_q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        clear_obs();
        for (int c = 0; c < 12; c++) run_cycle(1'b1);
        check("post_rst_first_word", 64'(obs_first), 64'd3);
        check("post_rst_pops", 64'(obs_pops), 64'd1);

        // Backpressure on a single line.
        clear_obs();
        push_line(make_line(50), 6'h2C);
        for (int c = 0; c < 60; c++) run_cycle(1'($urandom_range(0, 1)));
        for (int c = 0; c < 12; c++) run_cycle(1'b1);
        check("bp_beats", 64'(obs_beats), 64'(NB));
        check("bp_last_word", 64'(obs_last), 64'd4);

        // Random traffic.
        for (int c = 0; c < 600; c++) begin
            if (fifo_q.size() < 3 && $urandom_range(0, 3) == 0)
                push_line(rand_line(), 6'($urandom));
            run_cycle(1'($urandom_range(0, 1)));
        end
        for (int c = 0; c < 60 && (exp_q.size() != 0 || fifo_q.size() != 0); c++)
            run_cycle(1'b1);
        check("drain_done", 64'(exp_q.size() + fifo_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
